// File: rtl/if_prefetch_unit_if.sv
// Memory-side fetch channel of if_prefetch_unit: valid/ready request, in-order word response.
// master = prefetch unit, slave = instruction memory.
interface if_prefetch_unit_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    modport master (
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data
    );
endinterface

// File: rtl/if_prefetch_unit.sv
// Instruction prefetch front-end: sequential word fetches into a DEPTH-entry FIFO feeding decode.
// Define IF_PREFETCH_BYPASS_EN to let a response reach decode in the same cycle when the FIFO is empty.
module if_prefetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc,
    input  logic               stall,
    output logic               instr_valid,
    output logic [31:0]        instr,
    output logic [31:0]        instr_pc,
    if_prefetch_unit_if.master mem
);
    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW  = AW + 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [AW-1:0] ptr_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] rsp_pc_q, rsp_pc_d;
    logic        req_valid_q, req_valid_d;
    logic        req_stale_q, req_stale_d;
    cnt_t        outstanding_q, outstanding_d;
    cnt_t        discard_q, discard_d;
    cnt_t        count_q, count_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    ptr_t        wr_ptr_q, wr_ptr_d;

    logic [31:0] data_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];

    logic        accept, held, rsp_drop, rsp_live, fifo_empty, bypass, push, pop;
    cnt_t        disc_after, out_after;
    logic [31:0] base_pc;

    // rsp_live: a response that belongs to the current fetch stream (not stale, not after reset)
    always_comb begin
        accept     = req_valid_q & mem.mem_req_ready;
        held       = req_valid_q & ~mem.mem_req_ready;
        fifo_empty = (count_q == '0);
        rsp_drop   = mem.mem_rsp_valid & (discard_q != '0);
        rsp_live   = mem.mem_rsp_valid & (discard_q == '0) & (outstanding_q != '0);
`ifdef IF_PREFETCH_BYPASS_EN
        bypass     = fifo_empty & rsp_live & ~redirect_i;
`else
        bypass     = 1'b0;
`endif
        pop        = ~fifo_empty & ~stall & ~redirect_i;
        push       = rsp_live & ~redirect_i & ~(bypass & ~stall);

        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
        instr_valid = ~fifo_empty | bypass;
        instr       = NOP;
        instr_pc    = '0;
        if (bypass) begin
            instr    = mem.mem_rsp_data;
            instr_pc = rsp_pc_q;
        end else if (!fifo_empty) begin
            instr    = data_mem[rd_ptr_q];
            instr_pc = pc_mem[rd_ptr_q];
        end
    end

    // NOTE: combinational next-state uses blocking '='; only the always_ff blocks use '<='.
    always_comb begin
        disc_after = discard_q - cnt_t'(rsp_drop);
        out_after  = outstanding_q + cnt_t'(accept & ~req_stale_q) - cnt_t'(rsp_live);
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (redirect_i) begin
            // Everything still in flight, plus a held not-yet-counted request, becomes stale.
            discard_d     = disc_after + out_after + cnt_t'(held & ~req_stale_q);
            outstanding_d = '0;
            count_d       = '0;
            wr_ptr_d      = rd_ptr_q;
            rsp_pc_d      = redirect_pc & 32'hFFFF_FFFC;
            base_pc       = redirect_pc & 32'hFFFF_FFFC;
            req_stale_d   = held;
        end else begin
            discard_d     = disc_after;
            outstanding_d = out_after;
            count_d       = count_q + cnt_t'(push) - cnt_t'(pop);
            rd_ptr_d      = rd_ptr_q + ptr_t'(pop);
            wr_ptr_d      = wr_ptr_q + ptr_t'(push);
            rsp_pc_d      = rsp_live ? rsp_pc_q + 32'd4 : rsp_pc_q;
            base_pc       = fetch_pc_q;
            req_stale_d   = held & req_stale_q;
        end

        req_valid_d = 1'b0;
        req_addr_d  = req_addr_q;
        fetch_pc_d  = base_pc;
        if (held) begin
            req_valid_d = 1'b1;
        end else if ((count_d + outstanding_d < DEPTH_C) && (outstanding_d + discard_d < DEPTH_C)) begin
            req_valid_d = 1'b1;
            req_addr_d  = base_pc;
            fetch_pc_d  = base_pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC & 32'hFFFF_FFFC;
            req_addr_q    <= '0;
            rsp_pc_q      <= RESET_PC & 32'hFFFF_FFFC;
            req_valid_q   <= 1'b0;
            req_stale_q   <= 1'b0;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            req_addr_q    <= req_addr_d;
            rsp_pc_q      <= rsp_pc_d;
            req_valid_q   <= req_valid_d;
            req_stale_q   <= req_stale_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // NOTE: FIFO storage has no reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= mem.mem_rsp_data;
            pc_mem[wr_ptr_q]   <= rsp_pc_q;
        end
    end

    assign mem.mem_req_valid = req_valid_q;
    assign mem.mem_req_addr  = req_addr_q;
endmodule
